// File: rtl/led_pkg.sv
// Shared LED-path definitions: fader state encoding and default sizing.
// Reused by the blinker bench and later LED blocks.
package led_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RISE = 2'd1,
        ST_ON   = 2'd2,
        ST_FALL = 2'd3
    } led_state_t;

    localparam int PWM_BITS_DEF = 8;
    localparam int RAMP_DIV_DEF = 4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for slow asynchronous levels.
// Width is parameterised; reset clears both stages.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // first stage may go metastable, second stage gives a clean level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/led_pwm_fader.sv
// Turns the blinker's square-wave level into ramped PWM fades.
// Duty only moves on PWM period boundaries so the LED never glitches.
module led_pwm_fader
    import led_pkg::*;
#(
    parameter int PWM_BITS = PWM_BITS_DEF,
    parameter int RAMP_DIV = RAMP_DIV_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                led_in,
    output logic                LED,
    output logic [PWM_BITS-1:0] duty,
    output logic                busy
);

    localparam int SW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PWM_BITS-1:0] MAX   = '1;
    localparam logic [PWM_BITS-1:0] MAXM1 = MAX - 1'b1;
    localparam logic [PWM_BITS-1:0] ONE   = PWM_BITS'(1);
    localparam logic [SW-1:0] STEP_LAST   = SW'(RAMP_DIV - 1);

    logic                lvl;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [SW-1:0]       step_cnt;
    led_state_t          state;
    logic                pwm_wrap;
    logic                step;
    logic                rev;
    logic                done;

    sync_2ff #(.W(1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (led_in),
        .q     (lvl)
    );

    assign pwm_wrap = (pwm_cnt == MAX);
    assign step     = pwm_wrap && (step_cnt == STEP_LAST);

    // rev: level disagrees with direction; done: last step of a fade
    always_comb begin
        rev  = 1'b0;
        done = 1'b0;
        unique case (state)
            ST_OFF:  rev = lvl;
            ST_RISE: begin
                rev  = !lvl;
                done = lvl && step && (duty >= MAXM1);
            end
            ST_ON:   rev = !lvl;
            ST_FALL: begin
                rev  = lvl;
                done = !lvl && step && (duty <= ONE);
            end
            default: rev = 1'b0;
        endcase
    end

    // free-running PWM ramp, held at zero while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else if (!en) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // counts PWM periods per duty step, restarted on every transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt <= '0;
        end else if (!en || rev || done) begin
            step_cnt <= '0;
        end else if (pwm_wrap) begin
            if (step_cnt == STEP_LAST) begin
                step_cnt <= '0;
            end else begin
                step_cnt <= step_cnt + 1'b1;
            end
        end
    end

    // fade FSM with duty register; a reversal wins over a same-edge step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_OFF;
            duty  <= '0;
            busy  <= 1'b0;
        end else if (!en) begin
            state <= ST_OFF;
            duty  <= '0;
            busy  <= 1'b0;
        end else begin
            unique case (state)
                ST_OFF: begin
                    if (rev) begin
                        state <= ST_RISE;
                        busy  <= 1'b1;
                    end
                end
                ST_RISE: begin
                    if (rev) begin
                        state <= ST_FALL;
                    end else if (done) begin
                        state <= ST_ON;
                        duty  <= MAX;
                        busy  <= 1'b0;
                    end else if (step) begin
                        duty  <= duty + 1'b1;
                    end
                end
                ST_ON: begin
                    if (rev) begin
                        state <= ST_FALL;
                        busy  <= 1'b1;
                    end
                end
                ST_FALL: begin
                    if (rev) begin
                        state <= ST_RISE;
                    end else if (done) begin
                        state <= ST_OFF;
                        duty  <= '0;
                        busy  <= 1'b0;
                    end else if (step) begin
                        duty  <= duty - 1'b1;
                    end
                end
                default: begin
                    state <= ST_OFF;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // registered LED compare; ends of the range are forced steady
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            LED <= 1'b0;
        end else if (!en || duty == '0) begin
            LED <= 1'b0;
        end else if (duty == MAX) begin
            LED <= 1'b1;
        end else begin
            LED <= (pwm_cnt < duty);
        end
    end

endmodule
